// File: rtl/nn_host_sequencer.sv
// Host-side sequencer for one accelerator inference: load input layer with the
// core held in reset, run to finished (or timeout), then stream results out.
module nn_host_sequencer #(
  parameter int NEURON_DATA_BUS_WIDTH    = 8,
  parameter int NEURON_ADDRESS_BUS_WIDTH = 10,
  parameter int INPUT_WORD_COUNT         = 784,
  parameter int RUN_TIMEOUT_CYCLES       = 65535,
  parameter int CYCLE_COUNT_WIDTH        = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                in_valid,
  input  logic [NEURON_DATA_BUS_WIDTH-1:0]    in_data,
  output logic                                in_ready,
  output logic                                out_valid,
  output logic [NEURON_DATA_BUS_WIDTH-1:0]    out_data,
  output logic                                out_last,
  input  logic                                out_ready,
  output logic                                busy,
  output logic                                done,
  output logic                                timeout_err,
  output logic [CYCLE_COUNT_WIDTH-1:0]        run_cycles,
  output logic                                accel_reset,
  input  logic                                accel_finished,
  input  logic [NEURON_ADDRESS_BUS_WIDTH-1:0] accel_result_base,
  input  logic [NEURON_ADDRESS_BUS_WIDTH-1:0] accel_result_count,
  output logic [NEURON_ADDRESS_BUS_WIDTH-1:0] ram_wr_adr,
  output logic [NEURON_DATA_BUS_WIDTH-1:0]    ram_wr_data,
  output logic                                ram_wr_en,
  output logic [NEURON_ADDRESS_BUS_WIDTH-1:0] ram_rd_adr,
  input  logic [NEURON_DATA_BUS_WIDTH-1:0]    ram_rd_data
);
  localparam int DW = NEURON_DATA_BUS_WIDTH;
  localparam int AW = NEURON_ADDRESS_BUS_WIDTH;
  localparam int CW = CYCLE_COUNT_WIDTH;
  localparam logic [AW-1:0] LAST_IDX = AW'(INPUT_WORD_COUNT - 1);
  localparam logic [CW-1:0] TIMEOUT  = CW'(RUN_TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CYC_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_RD_ISSUE, S_RD_WAIT, S_RD_PRESENT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] load_idx_q, load_idx_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] count_q, count_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic [CW-1:0] run_cycles_q, run_cycles_d;
  logic          timeout_err_q, timeout_err_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [AW-1:0] rd_adr_q, rd_adr_d;

  assign busy        = (state_q != S_IDLE);
  assign run_cycles  = run_cycles_q;
  assign timeout_err = timeout_err_q;
  assign out_data    = out_data_q;

  always_comb begin
    state_d       = state_q;
    load_idx_d    = load_idx_q;
    cyc_d         = cyc_q;
    base_d        = base_q;
    count_d       = count_q;
    rd_idx_d      = rd_idx_q;
    run_cycles_d  = run_cycles_q;
    timeout_err_d = timeout_err_q;
    out_data_d    = out_data_q;
    in_ready      = 1'b0;
    ram_wr_en     = 1'b0;
    ram_wr_adr    = '0;
    ram_wr_data   = '0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    done          = 1'b0;
    accel_reset   = 1'b1;
    ram_rd_adr    = rd_adr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_LOAD;
          load_idx_d    = '0;
          timeout_err_d = 1'b0;
        end
      end
      S_LOAD: begin
        in_ready    = 1'b1;
        ram_wr_adr  = load_idx_q;
        ram_wr_data = in_data;
        ram_wr_en   = in_valid & in_ready;
        if (ram_wr_en) begin
          load_idx_d = load_idx_q + AW'(1);
          if (load_idx_q == LAST_IDX) begin
            state_d = S_RUN;
            cyc_d   = '0;
          end
        end
      end
      S_RUN: begin
        accel_reset = 1'b0;
        cyc_d = (cyc_q == CYC_MAX) ? cyc_q : cyc_q + CW'(1);
        // finished takes priority over a timeout landing on the same cycle
        if (accel_finished) begin
          base_d       = accel_result_base;
          count_d      = accel_result_count;
          run_cycles_d = cyc_q;
          rd_idx_d     = '0;
          state_d      = (accel_result_count == '0) ? S_DONE : S_RD_ISSUE;
        end else if (cyc_q >= TIMEOUT) begin
          timeout_err_d = 1'b1;
          run_cycles_d  = cyc_q;
          state_d       = S_IDLE;
        end
      end
      S_RD_ISSUE: begin
        accel_reset = 1'b0;
        ram_rd_adr  = base_q + rd_idx_q;
        state_d     = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        accel_reset = 1'b0;
        out_data_d  = ram_rd_data;
        state_d     = S_RD_PRESENT;
      end
      S_RD_PRESENT: begin
        accel_reset = 1'b0;
        out_valid   = 1'b1;
        out_last    = (rd_idx_q == count_q - AW'(1));
        if (out_ready) begin
          rd_idx_d = rd_idx_q + AW'(1);
          state_d  = out_last ? S_DONE : S_RD_ISSUE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    rd_adr_d = ram_rd_adr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      load_idx_q    <= '0;
      cyc_q         <= '0;
      base_q        <= '0;
      count_q       <= '0;
      rd_idx_q      <= '0;
      run_cycles_q  <= '0;
      timeout_err_q <= 1'b0;
      out_data_q    <= '0;
      rd_adr_q      <= '0;
    end else begin
      state_q       <= state_d;
      load_idx_q    <= load_idx_d;
      cyc_q         <= cyc_d;
      base_q        <= base_d;
      count_q       <= count_d;
      rd_idx_q      <= rd_idx_d;
      run_cycles_q  <= run_cycles_d;
      timeout_err_q <= timeout_err_d;
      out_data_q    <= out_data_d;
      rd_adr_q      <= rd_adr_d;
    end
  end
endmodule

// File: tb/tb_nn_host_sequencer.sv
// Scoreboard bench: stimulus pushes expected RAM writes and result words; a
// negedge monitor pops and compares. A second instance exercises the timeout.
module tb_nn_host_sequencer;
  localparam int IWC = 784;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic       start, in_valid, in_ready, out_valid, out_last, out_ready;
  logic [7:0] in_data, out_data, ram_wr_data, ram_rd_data;
  logic       busy, done, timeout_err, accel_reset, accel_finished, ram_wr_en;
  logic [15:0] run_cycles;
  logic [9:0] accel_result_base, accel_result_count, ram_wr_adr, ram_rd_adr;

  nn_host_sequencer u_dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .done(done), .timeout_err(timeout_err),
    .run_cycles(run_cycles), .accel_reset(accel_reset), .accel_finished(accel_finished),
    .accel_result_base(accel_result_base), .accel_result_count(accel_result_count),
    .ram_wr_adr(ram_wr_adr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
    .ram_rd_adr(ram_rd_adr), .ram_rd_data(ram_rd_data)
  );

  logic       t_start, t_in_valid, t_in_ready, t_out_valid, t_out_last, t_out_ready;
  logic [7:0] t_in_data, t_out_data, t_wr_data, t_rd_data;
  logic       t_busy, t_done, t_timeout_err, t_accel_reset, t_fin, t_wr_en;
  logic [15:0] t_run_cycles;
  logic [9:0] t_base, t_count, t_wr_adr, t_rd_adr;

  nn_host_sequencer #(.INPUT_WORD_COUNT(4), .RUN_TIMEOUT_CYCLES(100)) u_to (
    .clk(clk), .reset(reset), .start(t_start), .in_valid(t_in_valid), .in_data(t_in_data),
    .in_ready(t_in_ready), .out_valid(t_out_valid), .out_data(t_out_data), .out_last(t_out_last),
    .out_ready(t_out_ready), .busy(t_busy), .done(t_done), .timeout_err(t_timeout_err),
    .run_cycles(t_run_cycles), .accel_reset(t_accel_reset), .accel_finished(t_fin),
    .accel_result_base(t_base), .accel_result_count(t_count),
    .ram_wr_adr(t_wr_adr), .ram_wr_data(t_wr_data), .ram_wr_en(t_wr_en),
    .ram_rd_adr(t_rd_adr), .ram_rd_data(t_rd_data)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int t_done_cnt = 0;
  logic [17:0] wr_q[$];
  logic [18:0] out_q[$];
  logic        prev_stall = 1'b0;
  logic [18:0] prev_out = '0;

  function automatic logic [7:0] pat(input int a);
    return 8'((a * 7 + 3) & 255);
  endfunction
  function automatic logic [7:0] exp_data(input int a);
    return (a < IWC) ? 8'(a & 255) : pat(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  // Neuron RAM environment: registered read, pattern-filled before first use.
  logic [7:0] mem [1024];
  logic       ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int a = 0; a < 1024; a++) mem[a] <= pat(a);
      ram_init <= 1'b1;
    end else if (ram_wr_en) begin
      mem[ram_wr_adr] <= ram_wr_data;
    end
    ram_rd_data <= mem[ram_rd_adr];
  end
  assign t_rd_data = 8'h00;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (ram_wr_en) begin
        if (wr_q.size() == 0) bad("unexpected_write", 32'({ram_wr_adr, ram_wr_data}));
        else begin
          chk("wr_adr_data", 32'({ram_wr_adr, ram_wr_data}), 32'(wr_q[0]));
          chk("wr_accel_reset", 32'(accel_reset), 32'd1);
          void'(wr_q.pop_front());
        end
      end
      if (prev_stall)
        chk("stall_hold", 32'({out_valid, ram_rd_adr, out_data, out_last}), 32'({1'b1, prev_out}));
      if (out_valid && out_q.size() == 0)
        bad("unexpected_out_valid", 32'({ram_rd_adr, out_data, out_last}));
      else if (out_valid && out_ready) begin
        chk("out_word", 32'({ram_rd_adr, out_data, out_last}), 32'(out_q[0]));
        void'(out_q.pop_front());
      end
      if (done) done_cnt <= done_cnt + 1;
      if (t_done) t_done_cnt <= t_done_cnt + 1;
      prev_stall <= out_valid && !out_ready;
      prev_out   <= {ram_rd_adr, out_data, out_last};
    end
  end

  task automatic chk_reset();
    chk("rst_ctl", 32'({busy, accel_reset, in_ready, out_valid, out_last, done, timeout_err, ram_wr_en}),
        32'(8'b0100_0000));
    chk("rst_data", 32'({out_data, run_cycles}), 32'd0);
    chk("rst_adr", 32'({ram_wr_adr, ram_wr_data, ram_rd_adr}), 32'd0);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", 32'({busy, accel_reset, in_ready}), 32'(3'b111));
  endtask

  task automatic load_words(input int n);
    for (int i = 0; i < n; i++) begin
      int t;
      in_valid = 1'b1;
      in_data  = 8'(i & 255);
      wr_q.push_back({10'(i), 8'(i & 255)});
      t = 0;
      while (!in_ready && t < 20) begin
        @(posedge clk); #1;
        t++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("load_all_written", 32'(wr_q.size()), 32'd0);
  endtask

  task automatic finish_after(input int k, input int b, input int c);
    repeat (k) @(posedge clk);
    #1;
    accel_finished     = 1'b1;
    accel_result_base  = 10'(b);
    accel_result_count = 10'(c);
    for (int j = 0; j < c; j++) begin
      int a;
      a = (b + j) % 1024;
      out_q.push_back({10'(a), exp_data(a), 1'(j == c - 1)});
    end
    @(posedge clk); #1;
    accel_finished = 1'b0;
    chk("run_cycles", 32'(run_cycles), 32'(k));
  endtask

  task automatic drain(input int n, input int stall_k, input int stall_n);
    for (int k = 0; k < n; k++) begin
      int t;
      t = 0;
      while (!out_valid && t < 20) begin
        @(posedge clk); #1;
        t++;
      end
      chk("drain_valid", 32'(out_valid), 32'd1);
      if (k == stall_k) repeat (stall_n) begin
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic async_reset();
    #1 reset = 1'b1;
    #1 chk_reset();
    wr_q.delete();
    out_q.delete();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    accel_finished = 1'b0; accel_result_base = '0; accel_result_count = '0;
    t_start = 1'b0; t_in_valid = 1'b0; t_in_data = '0; t_out_ready = 1'b0;
    t_fin = 1'b0; t_base = '0; t_count = '0;
    #12 chk_reset();
    @(posedge clk); #1;
    reset = 1'b0;

    // Full run: 500 run cycles, ten words from 900, word 3 stalled 7 cycles
    start_pulse();
    load_words(IWC);
    chk("accel_reset_run", 32'(accel_reset), 32'd0);
    finish_after(500, 900, 10);
    drain(10, 2, 7);
    chk("done_pulse_a", 32'(done), 32'd1);
    @(posedge clk); #1;
    chk("idle_a", 32'({busy, accel_reset, done}), 32'(3'b010));
    chk("done_cnt_a", 32'(done_cnt), 32'd1);
    chk("out_q_empty_a", 32'(out_q.size()), 32'd0);

    // Zero result words: straight to DONE
    start_pulse();
    load_words(IWC);
    finish_after(30, 5, 0);
    chk("done_pulse_b", 32'(done), 32'd1);
    @(posedge clk); #1;
    chk("idle_b", 32'({busy, out_valid}), 32'd0);
    chk("done_cnt_b", 32'(done_cnt), 32'd2);

    // Reset in the middle of LOAD
    start_pulse();
    load_words(300);
    async_reset();

    // Reset in the middle of readout (wrapping addresses 1020..1)
    start_pulse();
    load_words(IWC);
    finish_after(40, 1020, 6);
    drain(4, -1, 0);
    repeat (3) begin
      if (!out_valid) begin @(posedge clk); #1; end
    end
    chk("word5_valid", 32'(out_valid), 32'd1);
    async_reset();
    chk("done_cnt_c", 32'(done_cnt), 32'd2);

    // Clean full run after the aborts
    start_pulse();
    load_words(IWC);
    finish_after(20, 1020, 6);
    drain(6, -1, 0);
    chk("done_pulse_d", 32'(done), 32'd1);
    @(posedge clk); #1;
    chk("idle_d", 32'(busy), 32'd0);
    chk("done_cnt_d", 32'(done_cnt), 32'd3);
    chk("out_q_empty_d", 32'(out_q.size()), 32'd0);

    // Timeout on the short instance
    begin
      int t;
      t_start = 1'b1;
      @(posedge clk); #1;
      t_start = 1'b0;
      chk("to_in_ready", 32'(t_in_ready), 32'd1);
      t_in_valid = 1'b1;
      repeat (4) @(posedge clk);
      #1 t_in_valid = 1'b0;
      chk("to_run", 32'({t_busy, t_accel_reset}), 32'(2'b10));
      t = 0;
      while (t_busy && t < 300) begin
        @(posedge clk); #1;
        t++;
      end
      chk("to_cycles", 32'(t), 32'd101);
      chk("to_err", 32'({t_timeout_err, t_accel_reset, t_done}), 32'(3'b110));
      chk("to_run_cycles", 32'(t_run_cycles), 32'd100);
      repeat (3) @(posedge clk);
      #1 chk("to_sticky", 32'(t_timeout_err), 32'd1);
      chk("to_no_done", 32'(t_done_cnt), 32'd0);
      t_start = 1'b1;
      @(posedge clk); #1;
      t_start = 1'b0;
      chk("to_cleared", 32'({t_timeout_err, t_busy}), 32'(2'b01));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
